// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with valid/ready pop.
// Framing errors and dropped-on-full bytes are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              uart_rx,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W    = ADDR_W;
  localparam int unsigned FCNT_W   = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_q, push_d;
  logic [7:0]        push_byte_q, push_byte_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              pop;
  logic              wr_en;

  // Receiver: synchronizer plus bit-timing state machine
  always_comb begin
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = sync2_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (sync2_q) begin
            push_d      = 1'b1;
            push_byte_d = shift_q;
            state_d     = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    pop       = rx_valid_q && rx_ready;
    wr_en     = push_q && ((count_q < FCNT_W'(DEPTH)) || pop);
    overrun_d = push_q && !wr_en;
    mem_d     = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_byte_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + FCNT_W'(wr_en) - FCNT_W'(pop);
    rx_valid_d = (count_d != '0);
    rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus serialises bytes onto the line and
// queues the expected bytes; a monitor compares every popped byte and counts flag pulses.
module tb_uart_rx_fifo;

  localparam int unsigned C     = 21;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HALF  = C / 2;
  localparam int unsigned FRAME = 10 * C;
  // start edge seen by the input flop -> rx_valid high (2 sync + half bit + 9 bits + push)
  localparam int LAT = 2 + HALF + 9 * C + 1;

  logic          clk = 1'b0;
  logic          res;
  logic          uart_rx;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW:0]   fifo_count;
  logic          frame_err;
  logic          overrun;

  logic ready_force   = 1'b0;
  logic ready_rand_en = 1'b0;
  logic rand_bit      = 1'b0;
  assign rx_ready = ready_force | (ready_rand_en & rand_bit);

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clk        (clk),
    .res        (res),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Reference FIFO: a byte is kept only if fewer than DEPTH bytes are outstanding
  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() >= DEPTH) exp_ov++;
    else exp_q.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit check_lat,
                            input bit pop_at_push, input int reset_at);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    uart_rx = fr[0];
    for (int i = 1; i <= int'(FRAME); i++) begin
      tick();
      if (check_lat && i == LAT)     chk("latency_before", int'(rx_valid), 0);
      if (check_lat && i == LAT + 1) chk("latency_at", int'(rx_valid), 1);
      if (pop_at_push) ready_force = (i == LAT);
      if (i == LAT + 1 && stop_bit && reset_at < 0) model_push(b);
      if (i == reset_at) res = 1'b1;
      if (reset_at >= 0 && i == reset_at + 1) begin
        res = 1'b0;
        exp_q.delete();
        chk("rst_mid_valid", int'(rx_valid), 0);
        chk("rst_mid_count", int'(fifo_count), 0);
        chk("rst_mid_data", int'(rx_data), 0);
        chk("rst_mid_ferr", int'(frame_err), 0);
        chk("rst_mid_ovr", int'(overrun), 0);
      end
      if (i < int'(FRAME)) uart_rx = fr[i/C];
    end
    if (reset_at < 0 && !stop_bit) exp_fe++;
  endtask

  task automatic wait_drain(input string name);
    ready_force = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    chk(name, exp_q.size(), 0);
    ready_force = 1'b0;
    tick();
    chk({name, "_count"}, int'(fifo_count), 0);
  endtask

  task automatic check_level(input string name);
    chk({name, "_count"}, int'(fifo_count), exp_q.size());
    chk({name, "_valid"}, int'(rx_valid), int'(exp_q.size() != 0));
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!res) begin
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", int'(rx_data), -1);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("pop_data", int'(rx_data), int'(mon_exp));
          end
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err || overrun) chk("flags_exclusive", int'(frame_err & overrun), 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rand_bit = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    res     = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_ovr", int'(overrun), 0);
    res = 1'b0;
    idle(5);

    // single byte, exact latency, one-cycle pop
    send_frame(8'h41, 1'b1, 1'b1, 1'b0, -1);
    idle(C);
    chk("single_count", int'(fifo_count), 1);
    chk("single_head", int'(rx_data), 8'h41);
    chk("single_valid", int'(rx_valid), 1);
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    tick();
    chk("single_after_pop_count", int'(fifo_count), 0);
    chk("single_after_pop_valid", int'(rx_valid), 0);

    // back-to-back "a".."z" with the consumer always ready
    ready_force = 1'b1;
    for (int c = 8'h61; c <= 8'h7A; c++) send_frame(8'(c), 1'b1, 1'b0, 1'b0, -1);
    idle(2 * C);
    ready_force = 1'b0;
    chk("loop_all_popped", exp_q.size(), 0);
    chk("loop_ferr", fe_cnt, 0);
    chk("loop_ovr", ov_cnt, 0);

    // short low glitch is rejected at the start-bit centre check
    uart_rx = 1'b0;
    idle(HALF / 2);
    uart_rx = 1'b1;
    idle(FRAME + C);
    chk("glitch_count", int'(fifo_count), 0);
    chk("glitch_valid", int'(rx_valid), 0);
    chk("glitch_ferr", fe_cnt, exp_fe);

    // framing error followed by a long break, then a clean byte
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    idle(600);
    uart_rx = 1'b1;
    idle(2 * C);
    chk("ferr_once", fe_cnt, 1);
    chk("ferr_count", int'(fifo_count), 0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, -1);
    idle(C);
    check_level("after_ferr");
    wait_drain("after_ferr_drain");

    // fill to depth, overrun on the 17th byte, drain, then wrap
    for (int v = 0; v < 17; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, 1'b0, -1);
      if (v == 15) chk("full_count", int'(fifo_count), 16);
    end
    chk("ovr_count", int'(fifo_count), 16);
    chk("ovr_pulse", ov_cnt, 1);
    chk("ovr_model", ov_cnt, exp_ov);
    wait_drain("ovr_drain");
    send_frame(8'h20, 1'b1, 1'b0, 1'b0, -1);
    idle(C);
    chk("wrap_head", int'(rx_data), 8'h20);
    wait_drain("wrap_drain");

    // full FIFO with a pop on the push cycle: accepted, no overrun
    for (int v = 0; v < 16; v++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
    chk("refill_count", int'(fifo_count), 16);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, -1);
    chk("simul_count", int'(fifo_count), 16);
    chk("simul_no_ovr", ov_cnt, 1);
    wait_drain("simul_drain");

    // reset during bit 3 of 0x7E, with one byte already buffered
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    idle(C);
    chk("pre_rst_count", int'(fifo_count), 1);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, int'(4 * C + HALF));
    // the low d7 of the abandoned frame is a fresh start edge; the high line that follows reads as 0xFF
    exp_q.push_back(8'hFF);
    idle(FRAME + 2 * C);
    check_level("post_rst_phantom");
    wait_drain("post_rst_drain");
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, -1);
    idle(C);
    chk("post_rst_head", int'(rx_data), 8'h7E);
    wait_drain("post_rst_7e");

    // random bytes, random gaps, random consumer
    ready_rand_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      idle(int'($urandom_range(0, 2 * C)));
      send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
    end
    ready_rand_en = 1'b0;
    wait_drain("rand_drain");

    chk("total_ferr", fe_cnt, exp_fe);
    chk("total_ovr", ov_cnt, exp_ov);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
